// File: rtl/npu_pkg.sv
// Shared NPU definitions: default array geometry, the packed result-row type
// and a lane slice helper.
package npu_pkg;

  localparam int NPU_N         = 8;
  localparam int NPU_ACC_WIDTH = 32;

  typedef logic [NPU_N*NPU_ACC_WIDTH-1:0] row_t;

  function automatic logic [NPU_ACC_WIDTH-1:0] lane_of(input row_t row, input int j);
    return row[j*NPU_ACC_WIDTH +: NPU_ACC_WIDTH];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, occupancy count and same-cycle
// push/pop (a push into a full FIFO is accepted when a pop happens alongside).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // storage carries no reset; only the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/systolic_result_collector.sv
// De-skews time-skewed systolic column results into rows, buffers them and
// streams them out with a tile-end marker. Optional clamp: COLLECTOR_RELU_EN.
module systolic_result_collector
  import npu_pkg::*;
#(
  parameter int N         = NPU_N,
  parameter int ACC_WIDTH = NPU_ACC_WIDTH,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N-1:0]             col_valid,
  input  logic [N*ACC_WIDTH-1:0]   y_in,
  input  logic [15:0]              tile_rows,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [N*ACC_WIDTH-1:0]   m_data,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     almost_full,
  output logic                     overflow_err,
  output logic                     misalign_err,
  input  logic                     clear_err
);

  localparam int RW = N*ACC_WIDTH;
  localparam int CW = $clog2(DEPTH)+1;
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH-AF_MARGIN);

  logic [RW-1:0] al_row;
  logic [RW-1:0] wr_row;
  logic [RW-1:0] head_row;
  logic [N-1:0]  al_v;
  logic          all_v;
  logic          any_v;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          ovf_event;
  logic          mis_event;
  logic [15:0]   row_cnt;

  // lane j is delayed N-1-j cycles so every lane of a vector lines up
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int D = N-1-j;
    if (D == 0) begin : g_pass
      assign al_row[j*ACC_WIDTH +: ACC_WIDTH] = y_in[j*ACC_WIDTH +: ACC_WIDTH];
      assign al_v[j] = col_valid[j];
    end else begin : g_dly
      logic [ACC_WIDTH-1:0] d_q [D];
      logic [D-1:0]         v_q;

      always_ff @(posedge clk) begin
        d_q[0] <= y_in[j*ACC_WIDTH +: ACC_WIDTH];
        for (int k = 1; k < D; k++) d_q[k] <= d_q[k-1];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) v_q <= '0;
        else        v_q <= (v_q << 1) | D'(col_valid[j]);
      end

      assign al_row[j*ACC_WIDTH +: ACC_WIDTH] = d_q[D-1];
      assign al_v[j] = v_q[D-1];
    end
  end

  assign all_v = &al_v;
  assign any_v = |al_v;

`ifdef COLLECTOR_RELU_EN
  always_comb begin
    wr_row = al_row;
    for (int j = 0; j < N; j++) begin
      if (al_row[j*ACC_WIDTH + ACC_WIDTH-1]) wr_row[j*ACC_WIDTH +: ACC_WIDTH] = '0;
    end
  end
`else
  assign wr_row = al_row;
`endif

  assign pop       = m_valid && m_ready;
  assign push      = all_v && (!fifo_full || pop);
  assign ovf_event = all_v && fifo_full && !pop;
  assign mis_event = any_v && !all_v;

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (wr_row),
    .pop       (pop),
    .pop_data  (head_row),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign m_valid     = !fifo_empty;
  assign m_data      = m_valid ? head_row : '0;
  assign almost_full = (fifo_count >= AF_LEVEL);

  // tile_rows == 0 disables the marker and lets the counter free-run
  assign m_last = m_valid && (tile_rows != 16'd0) && (row_cnt == tile_rows - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n)     row_cnt <= '0;
    else if (pop)   row_cnt <= m_last ? 16'd0 : row_cnt + 16'd1;
  end

  // a new error event outranks a clear in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      overflow_err <= ovf_event || (overflow_err && !clear_err);
      misalign_err <= mis_event || (misalign_err && !clear_err);
    end
  end

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: deskew latency, back-pressure,
// tile marker, error flags, full+pop, mid-run reset and lane clamping.
module tb_systolic_result_collector;
  import npu_pkg::*;

  localparam int N     = 8;
  localparam int AW    = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     col_valid = '0;
  logic [N*AW-1:0]  y_in = '0;
  logic [15:0]      tile_rows = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [N*AW-1:0]  m_data;
  logic             m_last;
  logic [4:0]       fifo_count;
  logic             almost_full;
  logic             overflow_err;
  logic             misalign_err;
  logic             clear_err = 1'b0;

  int checks = 0;
  int errors = 0;

  logic lq[$];
  row_t dq[$];

  systolic_result_collector #(
    .N (N), .ACC_WIDTH (AW), .DEPTH (DEPTH), .AF_MARGIN (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .col_valid    (col_valid),
    .y_in         (y_in),
    .tile_rows    (tile_rows),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .fifo_count   (fifo_count),
    .almost_full  (almost_full),
    .overflow_err (overflow_err),
    .misalign_err (misalign_err),
    .clear_err    (clear_err)
  );

  always #5 clk = ~clk;

  // record every accepted output row (sampled mid-cycle, popped at next edge)
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      lq.push_back(m_last);
      dq.push_back(m_data);
    end
  end

  function automatic logic [31:0] lane_val(input logic [31:0] base, input int row, input int j);
    return base + 32'(row*256) + 32'(j);
  endfunction

  function automatic row_t exp_row(input logic [31:0] base, input int row);
    row_t r;
    logic [31:0] v;
    r = '0;
    for (int j = 0; j < N; j++) begin
      v = lane_val(base, row, j);
`ifdef COLLECTOR_RELU_EN
      if (v[31]) v = '0;
`endif
      r[j*AW +: AW] = v;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive `count` back-to-back skewed vectors; optional withheld lane, early
  // stop after max_k cycles, clear_err / m_ready pulses at a given cycle
  task automatic issue(input int first_row, input int count, input logic [31:0] base,
                       input int skip_lane, input int max_k, input int clr_at, input int rdy_at);
    int v;
    for (int k = 0; k < count+N-1 && (max_k < 0 || k < max_k); k++) begin
      for (int j = 0; j < N; j++) begin
        v = k - j;
        if (v >= 0 && v < count && j != skip_lane) begin
          col_valid[j]    = 1'b1;
          y_in[j*AW +: AW] = lane_val(base, first_row+v, j);
        end else begin
          col_valid[j]    = 1'b0;
          y_in[j*AW +: AW] = '0;
        end
      end
      if (clr_at >= 0) clear_err = (k == clr_at);
      if (rdy_at >= 0) m_ready = (k == rdy_at);
      tick();
    end
    col_valid = '0;
    y_in      = '0;
    clear_err = 1'b0;
    if (rdy_at >= 0) m_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; col_valid = '0; m_ready = 1'b0; clear_err = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0) begin
      errors++; $display("FAIL reset_out: m_valid=%0b m_last=%0b m_data=%h, required 0/0/0", m_valid, m_last, m_data);
    end
    checks++;
    if (fifo_count !== 5'd0 || almost_full !== 1'b0) begin
      errors++; $display("FAIL reset_count: count=%0d af=%0b, required 0/0", fifo_count, almost_full);
    end
    checks++;
    if (overflow_err !== 1'b0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ovf=%0b mis=%0b, required 0/0", overflow_err, misalign_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_vector();
    do_reset();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        col_valid[j]     = (k == j);
        y_in[j*AW +: AW] = (k == j) ? 32'(100+j) : '0;
      end
      tick();
      if (k == N-2) begin
        checks++;
        if (m_valid !== 1'b0) begin
          errors++; $display("FAIL single_early: m_valid=%0b one cycle before latency, required 0", m_valid);
        end
      end
    end
    col_valid = '0; y_in = '0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp_row(32'd100, 0)) begin
      errors++; $display("FAIL single_row: m_valid=%0b m_data=%h, required 1/%h", m_valid, m_data, exp_row(32'd100, 0));
    end
    checks++;
    if (fifo_count !== 5'd1) begin
      errors++; $display("FAIL single_count: count=%0d, required 1", fifo_count);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0 || m_data !== '0) begin
      errors++; $display("FAIL single_pop: m_valid=%0b count=%0d m_data=%h, required 0/0/0", m_valid, fifo_count, m_data);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] b;
    b = 32'h1000_0000;
    do_reset();
    issue(0, 7, b, -1, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd7 || almost_full !== 1'b0) begin
      errors++; $display("FAIL bp_af_below: count=%0d af=%0b, required 7/0", fifo_count, almost_full);
    end
    issue(7, 1, b, -1, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd8 || almost_full !== 1'b1) begin
      errors++; $display("FAIL bp_af_at: count=%0d af=%0b, required 8/1", fifo_count, almost_full);
    end
    issue(8, 8, b, -1, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd16 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL bp_full: count=%0d ovf=%0b, required 16/0", fifo_count, overflow_err);
    end
    issue(16, 1, b, -1, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd16 || overflow_err !== 1'b1) begin
      errors++; $display("FAIL bp_overflow: count=%0d ovf=%0b, required 16/1", fifo_count, overflow_err);
    end
    m_ready = 1'b1;
    for (int r = 0; r < 16; r++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_row(b, r)) begin
        errors++; $display("FAIL bp_drain row %0d: m_valid=%0b m_data=%h, required 1/%h", r, m_valid, m_data, exp_row(b, r));
      end
      tick();
    end
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0 || almost_full !== 1'b0) begin
      errors++; $display("FAIL bp_empty: m_valid=%0b count=%0d af=%0b, required 0/0/0", m_valid, fifo_count, almost_full);
    end
  endtask

  task automatic test_tile_marker();
    logic [5:0] pat;
    logic [31:0] b;
    b = 32'h2000_0000;
    do_reset();
    lq.delete(); dq.delete();
    tile_rows = 16'd3;
    m_ready   = 1'b1;
    issue(0, 6, b, -1, -1, -1, -1);
    tick(); tick(); tick();
    pat = '0;
    for (int i = 0; i < 6 && i < lq.size(); i++) pat[i] = lq[i];
    checks++;
    if (lq.size() != 6 || pat !== 6'b100100) begin
      errors++; $display("FAIL tile_last: rows=%0d pattern=%b, required 6/100100", lq.size(), pat);
    end
    for (int i = 0; i < 6 && i < dq.size(); i++) begin
      checks++;
      if (dq[i] !== exp_row(b, i)) begin
        errors++; $display("FAIL tile_data row %0d: got %h, required %h", i, dq[i], exp_row(b, i));
      end
    end
    tile_rows = 16'd1;
    lq.delete();
    issue(6, 1, b, -1, -1, -1, -1);
    tick(); tick(); tick();
    checks++;
    if (lq.size() != 1 || lq[0] !== 1'b1) begin
      errors++; $display("FAIL tile_wrap: rows=%0d last=%0b, required 1/1", lq.size(), (lq.size() > 0) ? lq[0] : 1'b0);
    end
    tile_rows = 16'd0;
    lq.delete();
    issue(7, 3, b, -1, -1, -1, -1);
    tick(); tick(); tick();
    pat = '0;
    for (int i = 0; i < 3 && i < lq.size(); i++) pat[i] = lq[i];
    checks++;
    if (lq.size() != 3 || pat !== 6'b000000) begin
      errors++; $display("FAIL tile_zero: rows=%0d pattern=%b, required 3/000000", lq.size(), pat);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_misalign();
    logic [31:0] b;
    b = 32'h3000_0000;
    do_reset();
    issue(0, 1, b, -1, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd1 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL mis_clean: count=%0d mis=%0b, required 1/0", fifo_count, misalign_err);
    end
    issue(1, 1, b, 3, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd1 || misalign_err !== 1'b1) begin
      errors++; $display("FAIL mis_set: count=%0d mis=%0b, required 1/1", fifo_count, misalign_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    checks++;
    if (misalign_err !== 1'b0) begin
      errors++; $display("FAIL mis_clear: mis=%0b, required 0", misalign_err);
    end
    issue(2, 1, b, 3, -1, N-1, -1);
    checks++;
    if (misalign_err !== 1'b1) begin
      errors++; $display("FAIL mis_clear_race: mis=%0b, required 1", misalign_err);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] b;
    b = 32'h4000_0000;
    do_reset();
    issue(0, 16, b, -1, -1, -1, -1);
    issue(16, 1, b, -1, -1, -1, N-1);
    checks++;
    if (fifo_count !== 5'd16 || overflow_err !== 1'b0) begin
      errors++; $display("FAIL fullpop: count=%0d ovf=%0b, required 16/0", fifo_count, overflow_err);
    end
    m_ready = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_row(b, r)) begin
        errors++; $display("FAIL fullpop_drain row %0d: m_valid=%0b m_data=%h, required 1/%h", r, m_valid, m_data, exp_row(b, r));
      end
      tick();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] b;
    b = 32'h5000_0000;
    do_reset();
    issue(0, 1, b, 5, -1, -1, -1);
    issue(1, 5, b, -1, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd5 || misalign_err !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: count=%0d mis=%0b, required 5/1", fifo_count, misalign_err);
    end
    issue(6, 2, b, -1, 3, -1, -1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0 || misalign_err !== 1'b0 || overflow_err !== 1'b0 || almost_full !== 1'b0) begin
      errors++; $display("FAIL rmid_post: m_valid=%0b count=%0d mis=%0b ovf=%0b af=%0b, required all 0",
                         m_valid, fifo_count, misalign_err, overflow_err, almost_full);
    end
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (m_valid !== 1'b0 || fifo_count !== 5'd0 || misalign_err !== 1'b0) begin
      errors++; $display("FAIL rmid_partial: m_valid=%0b count=%0d mis=%0b, required 0/0/0", m_valid, fifo_count, misalign_err);
    end
  endtask

  task automatic test_lane_values();
    logic [31:0] b;
    logic [31:0] want0;
    b = 32'hFFFF_FFF6;
`ifdef COLLECTOR_RELU_EN
    want0 = 32'h0000_0000;
`else
    want0 = 32'hFFFF_FFF6;
`endif
    do_reset();
    issue(0, 2, b, -1, -1, -1, -1);
    issue(0, 1, 32'h0000_000A, -1, -1, -1, -1);
    checks++;
    if (fifo_count !== 5'd3 || lane_of(m_data, 0) !== want0) begin
      errors++; $display("FAIL lane_neg: count=%0d lane0=%h, required 3/%h", fifo_count, lane_of(m_data, 0), want0);
    end
    m_ready = 1'b1;
    checks++;
    if (m_data !== exp_row(b, 0)) begin
      errors++; $display("FAIL lane_row0: got %h, required %h", m_data, exp_row(b, 0));
    end
    tick();
    checks++;
    if (m_data !== exp_row(b, 1)) begin
      errors++; $display("FAIL lane_row1: got %h, required %h", m_data, exp_row(b, 1));
    end
    tick();
    checks++;
    if (lane_of(m_data, 0) !== 32'h0000_000A || m_data !== exp_row(32'h0000_000A, 0)) begin
      errors++; $display("FAIL lane_pos: lane0=%h, required 0000000a", lane_of(m_data, 0));
    end
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_vector();
    test_back_pressure();
    test_tile_marker();
    test_misalign();
    test_full_pop();
    test_reset_mid();
    test_lane_values();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
